// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned multiply / divide engine that borrows the shared
// 16-bit ALU for one add or subtract per clock.
module alu_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             cmd_q;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic             zero_div;

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign zero_div = cmd_q && (m == '0);

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; start only matters in IDLE and DONE
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!cmd_q) begin
                    state_nxt = S_MUL;
                end else if (zero_div) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = start ? S_LOAD : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status flags and ALU request; bus stays quiet outside iterations
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        alu_op = 2'b00;
        alu_a  = '0;
        alu_b  = '0;
        unique case (state)
            S_LOAD: begin
                busy = 1'b1;
            end
            S_MUL: begin
                busy   = 1'b1;
                alu_op = 2'b00;
                alu_a  = hi;
                alu_b  = m;
            end
            S_DIV: begin
                busy   = 1'b1;
                alu_op = 2'b01;
                alu_a  = {hi[WIDTH-2:0], lo[WIDTH-1]};
                alu_b  = m;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // One shift-add or restoring-subtract step from the ALU response
    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        unique case (state)
            S_MUL: begin
                if (lo[0]) begin
                    hi_nxt = {alu_cout, alu_o[WIDTH-1:1]};
                    lo_nxt = {alu_o[0], lo[WIDTH-1:1]};
                end else begin
                    hi_nxt = {1'b0, hi[WIDTH-1:1]};
                    lo_nxt = {hi[0], lo[WIDTH-1:1]};
                end
            end
            S_DIV: begin
                if (hi[WIDTH-1] || alu_cout) begin
                    hi_nxt = alu_o;
                    lo_nxt = {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi_nxt = {hi[WIDTH-2:0], lo[WIDTH-1]};
                    lo_nxt = {lo[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                hi_nxt = hi;
                lo_nxt = lo;
            end
        endcase
    end

    // Operand capture, iteration state and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q     <= 1'b0;
            m         <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            div0      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else if (accept) begin
            cmd_q <= cmd;
            m     <= b;
            hi    <= '0;
            lo    <= a;
            cnt   <= '0;
            div0  <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (zero_div) begin
                        result_hi <= lo;
                        result_lo <= '1;
                        div0      <= 1'b1;
                    end
                end
                S_MUL, S_DIV: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result_hi <= hi_nxt;
                        result_lo <= lo_nxt;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule
